// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Program-counter sequencer and instruction-memory req/ack
//               handshake with stall, redirect and stale-response flush.
//               Optional macro PCSEQ_ALIGN_CHECK_EN enables the sticky
//               misaligned-redirect flag and forces target bits [30:31] to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int unsigned STEP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [0:31] fetch_pc,
  output logic        misalign_err
);

  localparam logic [0:31] c_step = 32'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] pend_pc_q, pend_pc_d;
  logic        flush_pend_q, flush_pend_d;
  logic        instr_valid_q, instr_valid_d;
  logic [0:31] fetch_pc_q, fetch_pc_d;
  logic [0:31] target;

`ifdef PCSEQ_ALIGN_CHECK_EN
  logic misalign_err_q, misalign_err_d;

  assign target = {redirect_pc[0:29], 2'b00};

  always_comb begin
    misalign_err_d = misalign_err_q | (redirect & (|redirect_pc[30:31]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= misalign_err_d;
    end
  end

  assign misalign_err = misalign_err_q;
`else
  assign target       = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    flush_pend_d  = flush_pend_q;
    instr_valid_d = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    imem_req      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          // A same-cycle redirect beats any pending target; either way the response is stale.
          if (redirect) begin
            pc_d         = target;
            flush_pend_d = 1'b0;
          end else if (flush_pend_q) begin
            pc_d         = pend_pc_q;
            flush_pend_d = 1'b0;
          end else begin
            pc_d          = pc_q + c_step;
            instr_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
          end
          if (stall) state_d = STALL;
        end else if (redirect) begin
          // Address must stay stable until ack, so park the target.
          pend_pc_d    = target;
          flush_pend_d = 1'b1;
        end
      end
      STALL: begin
        if (redirect) pc_d = target;
        if (!stall) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_pc_q     <= '0;
      flush_pend_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      flush_pend_q  <= flush_pend_d;
      instr_valid_q <= instr_valid_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_pc    = fetch_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed vector-table bench for pc_fetch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [31:0] fetch_pc;
  logic        misalign_err;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] fpc;
  } vec_t;

  vec_t vq[$];

  pc_fetch_sequencer #(
    .RESET_PC(32'h0000_0000),
    .STEP    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .instr_valid (instr_valid),
    .fetch_pc    (fetch_pc),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                     input logic ack, input logic chk, input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] fpc);
    vec_t e;
    e.rst = r; e.stall = s; e.rd = rd; e.rpc = rpc; e.ack = ack;
    e.chk = chk; e.req = req; e.addr = addr; e.v = v; e.fpc = fpc;
    vq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                       input logic ack);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_ack = ack;
    #1;
  endtask

  task automatic expect_out(input string name, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] fpc, input logic err);
    checks++;
    if (imem_req !== req || imem_addr !== addr || instr_valid !== v ||
        fetch_pc !== fpc || misalign_err !== err) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h valid=%b fetch_pc=%h err=%b, want req=%b addr=%h valid=%b fetch_pc=%h err=%b",
               name, imem_req, imem_addr, instr_valid, fetch_pc, misalign_err,
               req, addr, v, fpc, err);
    end
  endtask

  logic        exp_err6;
  logic [31:0] exp_tgt6;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;

    //   rst st rd rpc            ack chk req addr           v  fpc
    add(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0);
    add(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h4);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'hC,        1, 32'h8);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h10,       1, 32'hC);
    add(1, 0, 0, 32'h0,        0, 1, 1, 32'h10,       0, 32'hC);
    add(0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0);
    add(0, 1, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0);
    add(0, 1, 0, 32'h0,        1, 1, 0, 32'h8,        1, 32'h4);
    add(0, 1, 0, 32'h0,        0, 1, 0, 32'h8,        0, 32'h4);
    add(0, 1, 0, 32'h0,        0, 1, 0, 32'h8,        0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 1, 0, 32'h8,        0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h8,        0, 32'h4);
    add(0, 0, 1, 32'h100,      0, 1, 1, 32'h8,        0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h8,        0, 32'h4);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h8,        0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h100,      0, 32'h4);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h100,      0, 32'h4);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h104,      1, 32'h100);
    add(0, 0, 1, 32'h200,      0, 1, 1, 32'h104,      0, 32'h100);
    add(0, 0, 1, 32'h300,      0, 1, 1, 32'h104,      0, 32'h100);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h104,      0, 32'h100);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h300,      0, 32'h100);
    add(0, 0, 1, 32'h400,      0, 1, 1, 32'h300,      0, 32'h100);
    add(0, 0, 1, 32'h500,      1, 1, 1, 32'h300,      0, 32'h100);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'h500,      0, 32'h100);
    add(0, 0, 1, 32'hFFFF_FFFC,1, 1, 1, 32'h504,      1, 32'h500);
    add(0, 0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC,0, 32'h500);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h0,        1, 32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'hFFFF_FFFC);
    add(0, 1, 1, 32'h800,      0, 1, 0, 32'h4,        1, 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 0, 32'h800,      0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'h800,      0, 32'h0);
    add(1, 0, 0, 32'h0,        0, 1, 1, 32'h800,      0, 32'h0);
    add(0, 0, 1, 32'hC00,      0, 1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0, 32'h0,        0, 1, 1, 32'hC00,      0, 32'h0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].stall, vq[i].rd, vq[i].rpc, vq[i].ack);
      if (vq[i].chk)
        expect_out($sformatf("vec%0d", i), vq[i].req, vq[i].addr, vq[i].v, vq[i].fpc, 1'b0);
    end

`ifdef PCSEQ_ALIGN_CHECK_EN
    exp_err6 = 1'b1;
    exp_tgt6 = 32'h100;
`else
    exp_err6 = 1'b0;
    exp_tgt6 = 32'h102;
`endif
    // Misaligned redirect while waiting, then reset mid-wait with a coincident ack.
    drive(1, 0, 0, 32'h0,   0);
    drive(0, 0, 0, 32'h0,   0);
    expect_out("mis_idle",     1'b0, 32'h0,    1'b0, 32'h0, 1'b0);
    drive(0, 0, 1, 32'h102, 0);
    expect_out("mis_redir",    1'b1, 32'h0,    1'b0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0,   0);
    expect_out("mis_flag",     1'b1, 32'h0,    1'b0, 32'h0, exp_err6);
    drive(0, 0, 0, 32'h0,   1);
    expect_out("mis_flush",    1'b1, 32'h0,    1'b0, 32'h0, exp_err6);
    drive(0, 0, 0, 32'h0,   0);
    expect_out("mis_target",   1'b1, exp_tgt6, 1'b0, 32'h0, exp_err6);
    drive(1, 0, 0, 32'h0,   1);
    drive(0, 0, 0, 32'h0,   1);
    expect_out("rst_midwait",  1'b0, 32'h0,    1'b0, 32'h0, 1'b0);
    drive(0, 0, 0, 32'h0,   0);
    expect_out("rst_ack_drop", 1'b1, 32'h0,    1'b0, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
